uart_cmd_parser: RTL and testbench
==================================

// Module: uart_cmd_parser
// PURPOSE
//  Consumes the byte stream from the UART receiver and runs the host debug protocol.
//  0x56 = write: 4 address bytes, then 4 data bytes. 0x55 = read: 4 address bytes.
//  Issues one 32-bit bus transaction per command.
//  Returns the result to the UART transmitter: 4 read-data bytes, or one ACK byte after a write.
//  Sits between uart_rx/uart_tx and the System bus arbiter.
// PARAMETERS
//  TIMEOUT_CYCLES  100000  max idle clocks between bytes of one command before abort (~4 ms @25 MHz)
//  CMD_READ        8'h55   read opcode
//  CMD_WRITE       8'h56   write opcode
//  ACK_BYTE        8'h06   byte returned after a completed write
// PORTS
//  clk        in   1   system clock (single clock domain)
//  reset      in   1   synchronous, active-high reset
//  rx_data    in   8   received byte, valid when rx_valid=1
//  rx_valid   in   1   1-cycle strobe per received byte
//  tx_data    out  8   byte to transmit
//  tx_valid   out  1   tx_data valid; held until accepted
//  tx_ready   in   1   transmitter accepts byte when tx_valid&tx_ready
//  bus_req    out  1   bus transaction request
//  bus_we     out  1   1=write, 0=read
//  bus_addr   out  32  transaction address
//  bus_wdata  out  32  write data
//  bus_ack    in   1   1-cycle completion strobe
//  bus_rdata  in   32  read data, valid in bus_ack cycle
//  busy       out  1   1 in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, counters 0. Reset mid-command or mid-bus-cycle aborts at once.
//  A pending bus_ack after reset is ignored.
//  States: IDLE, ADDR, WDATA, BUS, TX.
//  Multi-byte fields are little-endian: the first byte goes to bits [7:0].
//  Each field uses a 2-bit byte index that wraps 3->0 on field completion.
//  IDLE:
//    rx_valid & CMD_WRITE -> ADDR, we=1.
//    rx_valid & CMD_READ  -> ADDR, we=0.
//    Any other byte is discarded; state stays IDLE.
//  ADDR: each rx_valid shifts a byte into addr.
//    After the 4th byte: WDATA if we=1, else BUS.
//  WDATA: each rx_valid shifts a byte into wdata. After the 4th byte -> BUS.
//  BUS: bus_req=1 on the cycle after entry.
//    bus_addr, bus_we and bus_wdata stay stable while bus_req=1.
//    On bus_ack: bus_req drops in the same edge, bus_rdata is captured, state -> TX.
//    No bus timeout applies.
//  TX:
//    Read: sends 4 bytes, rdata[7:0] first.
//    Write: sends ACK_BYTE once.
//    tx_valid stays high with stable tx_data until tx_valid&tx_ready.
//    After the last accepted byte -> IDLE.
//    Back-to-back bytes are allowed when tx_ready is held high.
//  rx_valid arriving in BUS or TX is dropped, with no effect on state.
//  Timeout counter:
//    Clears on every rx_valid.
//    Counts only in ADDR and WDATA.
//    At TIMEOUT_CYCLES-1 -> IDLE; partial addr/wdata is discarded and no bus request is made.
//  Latency, last write-data byte to bus_req: 1 clk. bus_ack to first tx_valid: 1 clk.
//  A rx_valid in the same cycle as a timeout: the timeout wins; the byte is dropped.
// STRUCTURE
//  uart_cmd_defs.vh holds:
//    - opcodes CMD_READ/CMD_WRITE
//    - ACK_BYTE
//    - state encodings S_IDLE..S_TX (3-bit)
//  Sub-module uart_cmd_timeout:
//    - parameterised down-counter, width $clog2(TIMEOUT_CYCLES)
//    - inputs clr and en; output expired
//  The FSM, shift registers and TX sequencer stay in uart_cmd_parser.
// TESTING
//  1. Write command 56 | 01 00 00 00 | FF 00 FF 00.
//     -> one bus_req with we=1, addr=0x00000001, wdata=0x00FF00FF; after bus_ack, tx sends 06; busy=0 afterwards.
//  2. Read command 55 | 01 00 00 00, with bus_rdata=0x00FF00FF at ack.
//     -> bus_req with we=0, addr=0x00000001; tx sends FF,00,FF,00 in order.
//  3. Bytes 12, 00 in IDLE -> no bus_req, no tx_valid, busy stays 0. A following 55 command is accepted normally.
//  4. Send 56 01 00, then hold rx idle for TIMEOUT_CYCLES.
//     -> FSM returns to IDLE with no bus_req; next 55 01 00 00 00 reads addr 0x00000001.
//  5. Hold tx_ready=0 for 50 clks during a read response.
//     -> tx_valid stays high, tx_data=FF is stable, no byte is skipped.
//     Bytes injected on rx during TX are ignored.
//  6. Assert reset while bus_req=1.
//     -> next clk: all outputs 0, state IDLE. A late bus_ack causes no tx.

Source files
------------

// File: rtl/uart_cmd_parser_pkg.sv
// rtl/uart_cmd_parser_pkg.sv - opcodes, reply byte and FSM state encoding for the debug command parser
package uart_cmd_parser_pkg;

  localparam logic [7:0] CMD_READ  = 8'h55;
  localparam logic [7:0] CMD_WRITE = 8'h56;
  localparam logic [7:0] ACK_BYTE  = 8'h06;

  localparam int TIMEOUT_CYCLES_DEF = 100000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_BUS   = 3'd3,
    S_TX    = 3'd4
  } state_t;

endpackage

// File: rtl/uart_cmd_timeout.sv
// rtl/uart_cmd_timeout.sv - inter-byte idle down-counter for an in-progress command
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Reload on every received byte, otherwise count down while a field is being collected
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Expiry does not look at clr, so a byte landing on the expiry cycle loses to the timeout
  assign expired = en && (cnt == '0);

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - UART debug protocol parser issuing 32-bit bus reads/writes
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  state_t      state;
  state_t      state_next;
  logic [1:0]  byte_idx;
  logic [1:0]  tx_idx;
  logic [1:0]  tx_idx_inc;
  logic [31:0] rdata;
  logic        we;
  logic        expired;
  logic        tx_last;
  logic        tx_fire;

  uart_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (rx_valid),
    .en      ((state == S_ADDR) || (state == S_WDATA)),
    .expired (expired)
  );

  assign tx_fire    = tx_valid && tx_ready;
  assign tx_last    = we || (tx_idx == 2'd3);
  assign tx_idx_inc = tx_idx + 2'd1;

  // Next-state decode; timeout is checked before rx so a coincident byte is dropped
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (rx_valid && ((rx_data == CMD_WRITE) || (rx_data == CMD_READ))) begin
          state_next = S_ADDR;
        end
      end
      S_ADDR: begin
        if (expired) begin
          state_next = S_IDLE;
        end else if (rx_valid && (byte_idx == 2'd3)) begin
          state_next = we ? S_WDATA : S_BUS;
        end
      end
      S_WDATA: begin
        if (expired) begin
          state_next = S_IDLE;
        end else if (rx_valid && (byte_idx == 2'd3)) begin
          state_next = S_BUS;
        end
      end
      S_BUS: begin
        if (bus_ack) begin
          state_next = S_TX;
        end
      end
      S_TX: begin
        if (tx_fire && tx_last) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register plus field shift-in, bus handshake and reply sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      byte_idx  <= 2'd0;
      tx_idx    <= 2'd0;
      we        <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
      bus_req   <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (rx_valid && (rx_data == CMD_WRITE)) begin
            we <= 1'b1;
          end else if (rx_valid && (rx_data == CMD_READ)) begin
            we <= 1'b0;
          end
        end
        S_ADDR: begin
          if (expired) begin
            byte_idx <= 2'd0;
            bus_addr <= '0;
          end else if (rx_valid) begin
            bus_addr[{byte_idx, 3'b000} +: 8] <= rx_data;
            byte_idx <= byte_idx + 2'd1;
          end
        end
        S_WDATA: begin
          if (expired) begin
            byte_idx  <= 2'd0;
            bus_addr  <= '0;
            bus_wdata <= '0;
          end else if (rx_valid) begin
            bus_wdata[{byte_idx, 3'b000} +: 8] <= rx_data;
            byte_idx <= byte_idx + 2'd1;
          end
        end
        S_BUS: begin
          if (bus_ack) begin
            bus_req  <= 1'b0;
            rdata    <= bus_rdata;
            tx_valid <= 1'b1;
            tx_data  <= we ? ACK_BYTE : bus_rdata[7:0];
            tx_idx   <= 2'd0;
          end
        end
        S_TX: begin
          if (tx_fire) begin
            if (tx_last) begin
              tx_valid <= 1'b0;
              tx_data  <= '0;
            end else begin
              tx_idx  <= tx_idx_inc;
              tx_data <= rdata[{tx_idx_inc, 3'b000} +: 8];
            end
          end
        end
        default: ;
      endcase
      if ((state != S_BUS) && (state_next == S_BUS)) begin
        bus_req <= 1'b1;
      end
    end
  end

  assign bus_we = we;
  assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - scoreboard bench for uart_cmd_parser
module tb_uart_cmd_parser;

  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  bus_exp_t   bus_q[$];
  logic [7:0] tx_q[$];

  uart_cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Bus monitor: each new request is popped against the scoreboard; fields must hold while requested
  logic        prev_req = 1'b0;
  bus_exp_t    held;
  always @(negedge clk) begin
    if (bus_req && !prev_req) begin
      if (bus_q.size() == 0) begin
        chk("bus_unexpected", 32'd1, 32'd0);
      end else begin
        bus_exp_t e;
        e = bus_q.pop_front();
        chk("bus_we", {31'd0, bus_we}, {31'd0, e.we});
        chk("bus_addr", bus_addr, e.addr);
        if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
      end
      held = '{we: bus_we, addr: bus_addr, wdata: bus_wdata};
    end else if (bus_req && prev_req) begin
      chk("bus_stable", {bus_we, bus_addr, bus_wdata} == held ? 32'd1 : 32'd0, 32'd1);
    end
    prev_req = bus_req;
  end

  // TX monitor: every accepted byte must be the next expected one
  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        chk("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
      end else begin
        logic [7:0] b;
        b = tx_q.pop_front();
        chk("tx_byte", {24'd0, tx_data}, {24'd0, b});
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] b[]);
    foreach (b[i]) send_byte(b[i]);
  endtask

  task automatic push_tx_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) tx_q.push_back(w[i*8 +: 8]);
  endtask

  task automatic bus_respond(input logic [31:0] rd);
    int n;
    n = 0;
    while (!bus_req && n < 100) begin
      tick(1);
      n++;
    end
    if (!bus_req) begin
      chk("bus_req_wait", 32'd0, 32'd1);
    end else begin
      bus_rdata = rd;
      bus_ack   = 1'b1;
      tick(1);
      bus_ack   = 1'b0;
      chk("ack_req_drop", {31'd0, bus_req}, 32'd0);
      chk("ack_tx_lat", {31'd0, tx_valid}, 32'd1);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 500) begin
      tick(1);
      n++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk(name, {tx_data, tx_valid, bus_req, bus_we, busy, 20'd0}, 32'd0);
    chk({name, "_addr"}, bus_addr, 32'd0);
    chk({name, "_wdata"}, bus_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk_outputs_zero("reset_state");
    reset = 1'b0;
    tick(1);

    // 1: write 56 | 01 00 00 00 | FF 00 FF 00
    bus_q.push_back('{we: 1'b1, addr: 32'h0000_0001, wdata: 32'h00FF_00FF});
    tx_q.push_back(8'h06);
    send_bytes('{8'h56, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00});
    chk("wr_req_lat", {31'd0, bus_req}, 32'd1);
    bus_respond(32'h1234_5678);
    wait_idle("wr_idle");
    tick(2);

    // 2: read 55 | 01 00 00 00, rdata 0x00FF00FF
    bus_q.push_back('{we: 1'b0, addr: 32'h0000_0001, wdata: 32'h0});
    push_tx_word(32'h00FF_00FF);
    send_bytes('{8'h55, 8'h01, 8'h00, 8'h00, 8'h00});
    chk("rd_req_lat", {31'd0, bus_req}, 32'd1);
    bus_respond(32'h00FF_00FF);
    wait_idle("rd_idle");
    tick(2);

    // 3: junk bytes in IDLE are discarded, then a normal read
    send_byte(8'h12);
    chk("junk1_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h00);
    chk("junk2_busy", {31'd0, busy}, 32'd0);
    tick(3);
    chk("junk_quiet", {30'd0, bus_req, tx_valid}, 32'd0);
    bus_q.push_back('{we: 1'b0, addr: 32'h1234_5678, wdata: 32'h0});
    push_tx_word(32'hDEAD_BEEF);
    send_bytes('{8'h55, 8'h78, 8'h56, 8'h34, 8'h12});
    bus_respond(32'hDEAD_BEEF);
    wait_idle("junk_rd_idle");
    tick(2);

    // 4: partial write then idle past the timeout; next read is clean
    send_bytes('{8'h56, 8'h01, 8'h00});
    tick(TMO - 5);
    chk("tmo_still_busy", {31'd0, busy}, 32'd1);
    tick(10);
    chk("tmo_aborted", {31'd0, busy}, 32'd0);
    bus_q.push_back('{we: 1'b0, addr: 32'h0000_0001, wdata: 32'h0});
    push_tx_word(32'hA5A5_5A5A);
    send_bytes('{8'h55, 8'h01, 8'h00, 8'h00, 8'h00});
    bus_respond(32'hA5A5_5A5A);
    wait_idle("tmo_rd_idle");
    tick(2);

    // 5: back-pressure on the read reply, with rx noise during BUS and TX
    tx_ready = 1'b0;
    bus_q.push_back('{we: 1'b0, addr: 32'h0102_0304, wdata: 32'h0});
    push_tx_word(32'h00FF_00FF);
    send_bytes('{8'h55, 8'h04, 8'h03, 8'h02, 8'h01});
    send_byte(8'h56);
    bus_respond(32'h00FF_00FF);
    for (int i = 0; i < 50; i++) begin
      if (i == 10) send_byte(8'h55);
      else if (i == 20) send_byte(8'h56);
      else tick(1);
      chk("bp_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hFF});
    end
    tx_ready = 1'b1;
    wait_idle("bp_idle");
    tick(3);
    chk("bp_no_echo", {30'd0, bus_req, tx_valid}, 32'd0);

    // 6: reset in the middle of a bus cycle; a late ack must not produce a reply
    bus_q.push_back('{we: 1'b0, addr: 32'hCAFE_0010, wdata: 32'h0});
    send_bytes('{8'h55, 8'h10, 8'h00, 8'hFE, 8'hCA});
    tick(2);
    chk("rst_pre_req", {31'd0, bus_req}, 32'd1);
    reset = 1'b1;
    tick(1);
    chk_outputs_zero("rst_abort");
    reset = 1'b0;
    bus_rdata = 32'h1111_2222;
    bus_ack   = 1'b1;
    tick(1);
    bus_ack   = 1'b0;
    tick(5);
    chk("late_ack_quiet", {29'd0, bus_req, tx_valid, busy}, 32'd0);

    chk("bus_q_empty", bus_q.size(), 32'd0);
    chk("tx_q_empty", tx_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
